// File: rtl/clock_ctrl_pkg.sv
// Shared mode/alarm state types and the mode-to-field decode for the clock front panel.
// Pure types and functions; no timing or flow control of its own.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_TMIN = 3'd1,
        SET_THRS = 3'd2,
        SET_TDAY = 3'd3,
        SET_AMIN = 3'd4,
        SET_AHRS = 3'd5,
        SET_ADAY = 3'd6
    } mode_t;

    typedef enum logic [1:0] {
        A_OFF    = 2'd0,
        A_ARMED  = 2'd1,
        A_RING   = 2'd2,
        A_SNOOZE = 2'd3
    } alarm_t;

    typedef enum logic [1:0] {
        F_NONE = 2'd0,
        F_MIN  = 2'd1,
        F_HRS  = 2'd2,
        F_DAY  = 2'd3
    } field_t;

    function automatic field_t mode_field(input mode_t m);
        case (m)
            SET_TMIN, SET_AMIN: return F_MIN;
            SET_THRS, SET_AHRS: return F_HRS;
            SET_TDAY, SET_ADAY: return F_DAY;
            default:            return F_NONE;
        endcase
    endfunction

    function automatic mode_t mode_step(input mode_t m);
        case (m)
            RUN:      return SET_TMIN;
            SET_TMIN: return SET_THRS;
            SET_THRS: return SET_TDAY;
            SET_TDAY: return SET_AMIN;
            SET_AMIN: return SET_AHRS;
            SET_AHRS: return SET_ADAY;
            default:  return RUN;
        endcase
    endfunction

    function automatic logic is_time_set(input mode_t m);
        return (m == SET_TMIN) || (m == SET_THRS) || (m == SET_TDAY);
    endfunction

    function automatic logic is_alarm_set(input mode_t m);
        return (m == SET_AMIN) || (m == SET_AHRS) || (m == SET_ADAY);
    endfunction

endpackage

// File: rtl/btn_rpt.sv
// Button edge detect plus hold-to-repeat: one event on press, then every RPT_PER cycles after HOLD_DLY.
// press/evt are combinational from btn and registered history; clr kills repeats until a fresh press.
module btn_rpt #(
    parameter int HOLD_DLY = 2,
    parameter int RPT_PER  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clr,
    output logic press,
    output logic evt
);

    localparam int HMAX = HOLD_DLY + RPT_PER;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int RW   = $clog2(RPT_PER + 1);

    logic          btn_q;
    logic          active_q;
    logic [HW-1:0] h_q;
    logic [RW-1:0] rpt_q;
    logic          rpt_first;
    logic          rpt_later;

    // h_q holds the count up to the previous cycle, so this cycle's hold count is h_q+1
    assign press     = btn & ~btn_q;
    assign rpt_first = active_q & (h_q == HW'(HOLD_DLY));
    assign rpt_later = active_q & (h_q > HW'(HOLD_DLY)) & (rpt_q == '0);
    assign evt       = btn & ~clr & (press | rpt_first | rpt_later);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q    <= 1'b0;
            active_q <= 1'b0;
            h_q      <= '0;
            rpt_q    <= '0;
        end else begin
            btn_q <= btn;
            if (!btn || clr) begin
                active_q <= 1'b0;
                h_q      <= '0;
                rpt_q    <= '0;
            end else begin
                if (press)
                    active_q <= 1'b1;
                if (h_q != HW'(HMAX))
                    h_q <= h_q + HW'(1);
                if (rpt_first || rpt_later)
                    rpt_q <= RW'(RPT_PER - 1);
                else if (rpt_q != '0)
                    rpt_q <= rpt_q - RW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel mode/alarm controller: button presses to set-mode levels, advance pulses and buzzer drive.
// All outputs registered, one cycle after the sampled button edge; no backpressure from the datapath.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int HOLD_DLY   = 2,
    parameter int RPT_PER    = 1,
    parameter int IDLE_TO    = 30,
    parameter int RING_TO    = 60,
    parameter int SNOOZE_LEN = 540
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       adv_btn,
    input  logic       snooze_btn,
    input  logic       alm_en_btn,
    input  logic       alarm_match,
    output logic       timeset,
    output logic       alarmset,
    output logic       minadv,
    output logic       hrsadv,
    output logic       dayadv,
    output logic       alarm_on,
    output logic       buzz,
    output logic [2:0] mode_state
);

    localparam int IW    = $clog2(IDLE_TO + 1);
    localparam int CMAX  = (RING_TO > SNOOZE_LEN) ? RING_TO : SNOOZE_LEN;
    localparam int CW    = $clog2(CMAX + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TO - 1);
    localparam logic [CW-1:0] RING_LD   = CW'(RING_TO);
    localparam logic [CW-1:0] SNZ_LD    = CW'(SNOOZE_LEN);

    mode_t         mode_q, mode_nxt;
    alarm_t        alarm_q, alarm_nxt;
    logic [IW-1:0] idle_q;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          mode_btn_q, snz_btn_q, alm_btn_q, match_q;
    logic          mode_press, snz_press, alm_press, match_rise;
    logic          adv_press, adv_evt;
    field_t        fld;

    assign mode_press = mode_btn & ~mode_btn_q;
    assign snz_press  = snooze_btn & ~snz_btn_q;
    assign alm_press  = alm_en_btn & ~alm_btn_q;
    assign match_rise = alarm_match & ~match_q;
    assign fld        = mode_field(mode_q);
    assign mode_state = mode_q;

    btn_rpt #(
        .HOLD_DLY (HOLD_DLY),
        .RPT_PER  (RPT_PER)
    ) u_adv (
        .clk   (clk),
        .rst   (rst),
        .btn   (adv_btn),
        .clr   (mode_press),
        .press (adv_press),
        .evt   (adv_evt)
    );

    always_comb begin
        mode_nxt = mode_q;
        if (mode_press)
            mode_nxt = mode_step(mode_q);
        else if (mode_q != RUN && !adv_press && idle_q == IDLE_LAST)
            mode_nxt = RUN;
    end

    // Both timed alarm states leave on the cycle the counter holds 1, giving exactly N cycles in state
    always_comb begin
        alarm_nxt = alarm_q;
        cnt_nxt   = cnt_q;
        case (alarm_q)
            A_OFF: begin
                if (alm_press)
                    alarm_nxt = A_ARMED;
            end
            A_ARMED: begin
                if (alm_press) begin
                    alarm_nxt = A_OFF;
                end else if (match_rise && !alarmset) begin
                    alarm_nxt = A_RING;
                    cnt_nxt   = RING_LD;
                end
            end
            A_RING: begin
                if (alm_press) begin
                    alarm_nxt = A_OFF;
                end else if (snz_press) begin
                    alarm_nxt = A_SNOOZE;
                    cnt_nxt   = SNZ_LD;
                end else if (cnt_q <= CW'(1)) begin
                    alarm_nxt = A_ARMED;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            default: begin
                if (alm_press) begin
                    alarm_nxt = A_OFF;
                end else if (cnt_q <= CW'(1)) begin
                    alarm_nxt = A_RING;
                    cnt_nxt   = RING_LD;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= RUN;
            alarm_q    <= A_OFF;
            idle_q     <= '0;
            cnt_q      <= '0;
            mode_btn_q <= 1'b0;
            snz_btn_q  <= 1'b0;
            alm_btn_q  <= 1'b0;
            match_q    <= 1'b0;
            timeset    <= 1'b0;
            alarmset   <= 1'b0;
            minadv     <= 1'b0;
            hrsadv     <= 1'b0;
            dayadv     <= 1'b0;
            alarm_on   <= 1'b0;
            buzz       <= 1'b0;
        end else begin
            mode_q     <= mode_nxt;
            alarm_q    <= alarm_nxt;
            cnt_q      <= cnt_nxt;
            mode_btn_q <= mode_btn;
            snz_btn_q  <= snooze_btn;
            alm_btn_q  <= alm_en_btn;
            match_q    <= alarm_match;
            if (mode_press || adv_press || mode_nxt != mode_q || mode_q == RUN)
                idle_q <= '0;
            else
                idle_q <= idle_q + IW'(1);
            timeset  <= is_time_set(mode_nxt);
            alarmset <= is_alarm_set(mode_nxt);
            minadv   <= adv_evt && fld == F_MIN;
            hrsadv   <= adv_evt && fld == F_HRS;
            dayadv   <= adv_evt && fld == F_DAY;
            alarm_on <= alarm_nxt != A_OFF;
            buzz     <= alarm_nxt == A_RING;
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed vector table plus hand sequences for reset, idle timeout, snooze/ring timing and alarm corners.
module tb_clock_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       mode_btn, adv_btn, snooze_btn, alm_en_btn, alarm_match;
    logic       timeset, alarmset, minadv, hrsadv, dayadv, alarm_on, buzz;
    logic [2:0] mode_state;
    logic [9:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // {mode[2:0], timeset, alarmset, minadv, hrsadv, dayadv, alarm_on, buzz}
    assign outs = {mode_state, timeset, alarmset, minadv, hrsadv, dayadv, alarm_on, buzz};

    clock_mode_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mode_btn    (mode_btn),
        .adv_btn     (adv_btn),
        .snooze_btn  (snooze_btn),
        .alm_en_btn  (alm_en_btn),
        .alarm_match (alarm_match),
        .timeset     (timeset),
        .alarmset    (alarmset),
        .minadv      (minadv),
        .hrsadv      (hrsadv),
        .dayadv      (dayadv),
        .alarm_on    (alarm_on),
        .buzz        (buzz),
        .mode_state  (mode_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       a;
        logic       s;
        logic       e;
        logic       x;
        logic [9:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic m, input logic a, input logic s, input logic e,
                       input logic x, input logic [9:0] exp);
        vec_t v;
        v.m = m; v.a = a; v.s = s; v.e = e; v.x = x; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic m, input logic a, input logic s, input logic e, input logic x);
        mode_btn = m; adv_btn = a; snooze_btn = s; alm_en_btn = e; alarm_match = x;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1, guard;
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #3;
        check("reset_state", 16'(outs), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        //   m  a  s  e  x   mode_ts as_adv_onbz
        add(0, 0, 0, 0, 0, 10'b000_00_000_00);
        add(1, 0, 0, 0, 0, 10'b001_10_000_00);
        add(0, 0, 0, 0, 0, 10'b001_10_000_00);
        add(1, 0, 0, 0, 0, 10'b010_10_000_00);
        add(0, 0, 0, 0, 0, 10'b010_10_000_00);
        add(1, 0, 0, 0, 0, 10'b011_10_000_00);
        add(0, 0, 0, 0, 0, 10'b011_10_000_00);
        add(1, 0, 0, 0, 0, 10'b100_01_000_00);
        add(0, 0, 0, 0, 0, 10'b100_01_000_00);
        add(1, 0, 0, 0, 0, 10'b101_01_000_00);
        add(0, 0, 0, 0, 0, 10'b101_01_000_00);
        add(1, 0, 0, 0, 0, 10'b110_01_000_00);
        add(0, 1, 0, 0, 0, 10'b110_01_001_00);
        add(1, 0, 0, 0, 0, 10'b000_00_000_00);
        add(0, 1, 0, 0, 0, 10'b000_00_000_00);
        add(1, 0, 0, 0, 0, 10'b001_10_000_00);
        add(0, 0, 0, 0, 0, 10'b001_10_000_00);
        // adv held 6 cycles in SET_TMIN: pulses on output cycles 1,3,4,5,6
        add(0, 1, 0, 0, 0, 10'b001_10_100_00);
        add(0, 1, 0, 0, 0, 10'b001_10_000_00);
        add(0, 1, 0, 0, 0, 10'b001_10_100_00);
        add(0, 1, 0, 0, 0, 10'b001_10_100_00);
        add(0, 1, 0, 0, 0, 10'b001_10_100_00);
        add(0, 1, 0, 0, 0, 10'b001_10_100_00);
        add(0, 0, 0, 0, 0, 10'b001_10_000_00);
        // mode press while adv held: no event, no repeat until a fresh press
        add(0, 1, 0, 0, 0, 10'b001_10_100_00);
        add(1, 1, 0, 0, 0, 10'b010_10_000_00);
        add(0, 1, 0, 0, 0, 10'b010_10_000_00);
        add(0, 1, 0, 0, 0, 10'b010_10_000_00);
        add(0, 0, 0, 0, 0, 10'b010_10_000_00);
        add(0, 1, 0, 0, 0, 10'b010_10_010_00);
        add(0, 0, 0, 0, 0, 10'b010_10_000_00);
        // alarm: arm, ring on match edge, snooze, disable
        add(0, 0, 0, 1, 0, 10'b010_10_000_10);
        add(0, 0, 0, 0, 1, 10'b010_10_000_11);
        add(0, 0, 0, 0, 0, 10'b010_10_000_11);
        add(0, 0, 1, 0, 0, 10'b010_10_000_10);
        add(0, 0, 0, 0, 0, 10'b010_10_000_10);
        add(0, 0, 0, 1, 0, 10'b010_10_000_00);

        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].m, vq[i].a, vq[i].s, vq[i].e, vq[i].x);
            tick();
            check($sformatf("vec%0d", i), 16'(outs), 16'(vq[i].exp));
        end
        set_in(0, 0, 0, 0, 0);
        tick();

        // Reset while in SET_THRS and ringing
        alm_en_btn = 1; tick();
        alm_en_btn = 0; alarm_match = 1; tick();
        alarm_match = 0;
        check("pre_reset_ring", 16'(outs), 16'(10'b010_10_000_11));
        #2 rst = 1'b0;
        #1 check("async_reset", 16'(outs), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // alm_en beats snooze in the same cycle
        alm_en_btn = 1; tick();
        alm_en_btn = 0;
        check("arm_on", 16'(alarm_on), 16'd1);
        alarm_match = 1; tick();
        alarm_match = 0;
        check("ring_run", 16'(buzz), 16'd1);
        tick();
        snooze_btn = 1; alm_en_btn = 1; tick();
        snooze_btn = 0; alm_en_btn = 0;
        check("alm_beats_snooze", 16'({alarm_on, buzz}), 16'd0);
        tick();

        // Match held high across OFF->ARMED must not ring
        alarm_match = 1; tick();
        alm_en_btn = 1; tick();
        alm_en_btn = 0; tick(); tick();
        check("held_match_no_ring", 16'({alarm_on, buzz}), 16'b10);
        alarm_match = 0; tick();

        // Match edge while alarmset: no ring
        for (int k = 0; k < 4; k++) begin
            mode_btn = 1; tick();
            mode_btn = 0; tick();
        end
        check("in_set_amin", 16'({mode_state, alarmset}), 16'({3'd4, 1'b1}));
        alarm_match = 1; tick(); tick();
        check("alarmset_no_ring", 16'(buzz), 16'd0);
        alarm_match = 0; tick();

        // Idle timeout in SET_AHRS, restarted by an adv press at idle cycle 29
        mode_btn = 1; tick();
        mode_btn = 0;
        check("enter_ahrs", 16'(mode_state), 16'd5);
        repeat (29) tick();
        check("idle29_still_set", 16'(mode_state), 16'd5);
        adv_btn = 1; tick();
        adv_btn = 0;
        check("adv_press_restart", 16'({mode_state, hrsadv}), 16'({3'd5, 1'b1}));
        repeat (29) tick();
        check("idle_restart_29", 16'(mode_state), 16'd5);
        tick();
        check("idle_timeout_run", 16'({mode_state, timeset, alarmset}), 16'd0);

        // Ring, snooze 540 cycles, ring 60 cycles, back to armed
        alarm_match = 1; tick();
        alarm_match = 0;
        check("ring_start", 16'(buzz), 16'd1);
        snooze_btn = 1; tick();
        snooze_btn = 0;
        n0 = (buzz === 1'b0) ? 1 : 0;
        guard = 0;
        while (buzz === 1'b0 && guard < 700) begin
            tick();
            guard++;
            if (buzz === 1'b0) n0++;
        end
        check("snooze_len", 16'(n0), 16'd540);
        n1 = (buzz === 1'b1) ? 1 : 0;
        guard = 0;
        while (buzz === 1'b1 && guard < 100) begin
            tick();
            guard++;
            if (buzz === 1'b1) n1++;
        end
        check("ring_len", 16'(n1), 16'd60);
        check("back_armed", 16'({alarm_on, buzz}), 16'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Front-panel controller for the digital clock/alarm datapath. It turns three momentary buttons (mode, advance, snooze) and one alarm-enable button into the datapath's level controls: timeset, alarmset, minadv, hrsadv, dayadv. It also owns the alarm-enable state, and it sequences the buzzer with ring timeout and snooze. It sits between the panel inputs and the counter/alarm datapath and consumes that datapath's raw minute/hour/day match signal.

Parameters:
HOLD_DLY, 2, clk cycles adv must stay held after the initial pulse before auto-repeat starts (min 1)
RPT_PER, 1, clk cycles between auto-repeat pulses (min 1)
IDLE_TO, 30, cycles with no mode/adv press in a set state before forced return to RUN
RING_TO, 60, cycles the buzzer sounds before auto-silencing (back to ARMED)
SNOOZE_LEN, 540, cycles spent in SNOOZE before re-ringing

Ports:
clk  in  1  Pulse clock, 1 cycle/sec
rst  in  1  asynchronous, active-low reset
mode_btn  in  1  level, synchronous to clk; each press steps the mode FSM
adv_btn  in  1  level; advance button, with auto-repeat
snooze_btn  in  1  level; snooze while ringing
alm_en_btn  in  1  level; toggles alarm enable / dismisses a ringing alarm
alarm_match  in  1  datapath compare: time == alarm (min, hrs, day)
timeset  out  1  high in SET_TMIN/SET_THRS/SET_TDAY
alarmset  out  1  high in SET_AMIN/SET_AHRS/SET_ADAY
minadv  out  1  one-cycle advance pulse, minutes field
hrsadv  out  1  one-cycle advance pulse, hours field
dayadv  out  1  one-cycle advance pulse, days field
alarm_on  out  1  alarm enabled (any alarm state except A_OFF)
buzz  out  1  buzzer drive
mode_state  out  3  encoded mode state, for display and debug

Behaviour:
- All outputs are registered. On rst=0 (async): mode=RUN, alarm=A_OFF, all outputs 0, all counters and button history 0.
- Press detection: press = btn & ~btn_q, with btn_q registered each cycle. A held button produces exactly one press.
- Mode FSM order: RUN -> SET_TMIN -> SET_THRS -> SET_TDAY -> SET_AMIN -> SET_AHRS -> SET_ADAY -> RUN. Each mode press advances one step. Encoding is 0..6 in that order.
- Idle timer: cleared on any mode or adv press and on entering any state. It increments in the set states. When it reaches IDLE_TO-1 with no press that cycle, the next state is RUN.
- Advance generation:
  - h = consecutive cycles adv_btn has been sampled high, saturating at HOLD_DLY+RPT_PER; h = 1 on the press cycle.
  - An advance event occurs when h==1, or when h>HOLD_DLY and (h-1-HOLD_DLY) mod RPT_PER == 0. Use a repeat counter that reloads; h never wraps.
  - An event drives the field output matching the current state (MIN, HRS or DAY, time or alarm alike) high for exactly the next cycle. Latency is 1 cycle.
  - Events in RUN are discarded.
  - On a cycle with a mode press, the advance event is suppressed and h restarts at 0. The new field only advances on a fresh press.
- Alarm FSM:
  - A_OFF --alm_en press--> A_ARMED.
  - A_ARMED --rising edge of alarm_match while alarmset==0--> A_RING, ring counter loaded with RING_TO.
  - A_RING: buzz=1. A snooze press goes to A_SNOOZE and loads SNOOZE_LEN. When the ring counter expires, the state returns to A_ARMED.
  - A_SNOOZE: buzz=0. When the counter reaches 0, the state goes to A_RING with RING_TO reloaded. alarm_match edges are ignored here.
  - alm_en press in A_ARMED, A_RING or A_SNOOZE goes to A_OFF; buzz drops the next cycle.
  - alm_en press beats a snooze press in the same cycle.
  - A snooze press in A_OFF or A_ARMED has no effect.
  - A match edge while alarmset==1 never triggers ringing.
  - A match that stays high across A_OFF->A_ARMED does not ring, because the FSM is edge-only.
- The mode FSM and alarm FSM are independent. Ringing continues in set modes.
- Counter widths: $clog2(param+1); no overflow is possible.

Decomposition:
- Package clock_ctrl_pkg holds:
  - mode_t enum (RUN, SET_TMIN..SET_ADAY, 3 bits)
  - alarm_t enum (A_OFF, A_ARMED, A_RING, A_SNOOZE)
  - field select enum (F_NONE, F_MIN, F_HRS, F_DAY) and the state-to-field mapping function
- Sub-module btn_rpt (params HOLD_DLY and RPT_PER; ports clk, rst, btn, clr; outputs press, evt) handles edge detection and auto-repeat. Instantiate it once for adv_btn; simple press registers cover the other buttons.

Test Plan:
1. Reset mid-operation: drive rst low while in SET_THRS and A_RING -> immediately mode_state=0, buzz=0, alarm_on=0, all adv outputs 0.
2. Five mode presses from RUN -> mode_state 1,2,3,4,5. timeset=1 for states 1-3 and alarmset=1 for states 4-5; never both high.
3. In SET_TMIN, hold adv 6 cycles (defaults HOLD_DLY=2, RPT_PER=1) -> minadv pulses on output cycles 1,3,4,5,6; hrsadv and dayadv stay 0.
4. In SET_AHRS, idle 30 cycles -> mode_state=0 on cycle 30. An adv press at cycle 29 restarts the count.
5. Alarm armed, alarm_match rises -> buzz=1 next cycle. Snooze -> buzz=0 for 540 cycles, then buzz=1 for 60 cycles, then A_ARMED.
6. Same cycle alm_en and snooze while ringing -> A_OFF, alarm_on=0. A match rise with alarmset=1 -> buzz stays 0.
